// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter.
// Also holds a sizing helper for integrators.
package counter_pkg;

  localparam logic ST_RUN    = 1'b1;
  localparam logic ST_PAUSED = 1'b0;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {
    S_PAUSED = ST_PAUSED,
    S_RUN    = ST_RUN
  } state_t;

  // Bits needed to hold values 0..v-1
  function automatic int clog2(input longint v);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser with a rising-edge detector.
// Emits one div_clk-wide pulse per press.
module btn_edge_sync (
  input  logic div_clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse_out = sync2 & ~prev;

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with run/pause button,
// preload, wrap/saturate mode and terminal-count pulse.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 9,
  parameter int SATURATE  = 0,
  parameter int RESET_RUN = 1
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running
);

  if (MAX_VAL < 1 ||
      longint'(MAX_VAL) > ((64'sd1 <<< WIDTH) - 1))
  begin : g_bad_max
    $error("MAX_VAL out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_C =
    WIDTH'(MAX_VAL);

  localparam state_t RST_ST =
    (RESET_RUN != 0) ? S_RUN : S_PAUSED;

  logic press;

  btn_edge_sync u_sync (
    .div_clk   (div_clk),
    .rst       (rst),
    .btn_in    (run_btn),
    .pulse_out (press)
  );

  state_t state_q;
  state_t state_d;

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) state_q <= RST_ST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (press) begin
      unique case (state_q)
        S_RUN:    state_d = S_PAUSED;
        S_PAUSED: state_d = S_RUN;
        default:  state_d = RST_ST;
      endcase
    end
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             step_up;
  logic             step_dn;
  logic             at_max;
  logic             at_zero;

  assign step_up = (state_q == S_RUN) &&
                   (up_dn == DIR_UP);
  assign step_dn = (state_q == S_RUN) &&
                   (up_dn == DIR_DOWN);
  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);

  // Compare before stepping so no step can overflow
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    priority case (1'b1)
      load: begin
        count_d = (load_val > MAX_C) ? MAX_C
                                     : load_val;
      end
      step_up: begin
        if (at_max) begin
          count_d = (SATURATE != 0) ? MAX_C : '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      step_dn: begin
        if (at_zero) begin
          count_d = (SATURATE != 0) ? '0 : MAX_C;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign running = (state_q == S_RUN);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: wrap and saturate
// instances against a behavioural model.
module tb_updown_mod_counter;

  localparam int W  = 4;
  localparam int MX = 9;

  logic         div_clk = 1'b0;
  logic         rst;
  logic         run_btn;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc;
  logic         running;
  logic [W-1:0] cs;
  logic         ts;
  logic         rs;

  always #5 div_clk = ~div_clk;

  updown_mod_counter #(
    .WIDTH(W), .MAX_VAL(MX),
    .SATURATE(0), .RESET_RUN(1)
  ) dut (
    .div_clk(div_clk), .rst(rst),
    .run_btn(run_btn), .up_dn(up_dn),
    .load(load), .load_val(load_val),
    .count(count), .tc(tc), .running(running)
  );

  updown_mod_counter #(
    .WIDTH(W), .MAX_VAL(MX),
    .SATURATE(1), .RESET_RUN(1)
  ) dut_s (
    .div_clk(div_clk), .rst(rst),
    .run_btn(run_btn), .up_dn(up_dn),
    .load(load), .load_val(load_val),
    .count(cs), .tc(ts), .running(rs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: [0] wraps, [1] saturates
  int mc[2];
  bit mt[2];
  bit mrun;
  bit hq[3];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mc[0] = 0; mc[1] = 0;
    mt[0] = 0; mt[1] = 0;
    mrun  = 1;
    hq[0] = 0; hq[1] = 0; hq[2] = 0;
  endtask

  // Button seen at edge e-2 and not at e-3 toggles at e
  task automatic model_edge();
    bit pulse;
    int lv;
    pulse = hq[1] & ~hq[0];
    lv = int'(load_val);
    for (int s = 0; s < 2; s++) begin
      mt[s] = 0;
      if (load) begin
        mc[s] = (lv > MX) ? MX : lv;
      end else if (mrun && up_dn) begin
        if (mc[s] == MX) begin
          mc[s] = (s == 1) ? MX : 0;
          mt[s] = 1;
        end else mc[s] = mc[s] + 1;
      end else if (mrun) begin
        if (mc[s] == 0) begin
          mc[s] = (s == 1) ? 0 : MX;
          mt[s] = 1;
        end else mc[s] = mc[s] - 1;
      end
    end
    if (pulse) mrun = !mrun;
    hq[0] = hq[1];
    hq[1] = hq[2];
    hq[2] = run_btn;
  endtask

  task automatic check_all();
    chk("count", int'(count), mc[0]);
    chk("tc", int'(tc), int'(mt[0]));
    chk("running", int'(running), int'(mrun));
    chk("s_count", int'(cs), mc[1]);
    chk("s_tc", int'(ts), int'(mt[1]));
    chk("s_running", int'(rs), int'(mrun));
  endtask

  task automatic tick();
    @(posedge div_clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous: checked before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    chk("rst_count", int'(count), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_running", int'(running), 1);
    rst = 1'b0;
  endtask

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         up;
    int           ec;
    int           et;
  } vec_t;

  vec_t tbl[10];
  int   frozen;

  initial begin
    tbl[0] = '{1'b0, 4'd0,  1'b1, 1, 0};
    tbl[1] = '{1'b0, 4'd0,  1'b1, 2, 0};
    tbl[2] = '{1'b1, 4'd4,  1'b1, 4, 0};
    tbl[3] = '{1'b0, 4'd0,  1'b0, 3, 0};
    tbl[4] = '{1'b1, 4'd13, 1'b0, 9, 0};
    tbl[5] = '{1'b0, 4'd0,  1'b1, 0, 1};
    tbl[6] = '{1'b0, 4'd0,  1'b0, 9, 1};
    tbl[7] = '{1'b0, 4'd0,  1'b0, 8, 0};
    tbl[8] = '{1'b1, 4'd0,  1'b0, 0, 0};
    tbl[9] = '{1'b0, 4'd0,  1'b0, 9, 1};

    rst = 1'b1;
    run_btn = 1'b0;
    up_dn = 1'b1;
    load = 1'b0;
    load_val = '0;
    do_reset();

    // Table vectors from reset
    for (int i = 0; i < 10; i++) begin
      load = tbl[i].ld;
      load_val = tbl[i].lv;
      up_dn = tbl[i].up;
      tick();
      chk("tbl_count", int'(count), tbl[i].ec);
      chk("tbl_tc", int'(tc), tbl[i].et);
    end
    load = 1'b0;

    // Count up through the wrap / saturation
    do_reset();
    up_dn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("up_cnt", int'(count), i % 10);
      chk("up_tc", int'(tc), int'(i == 10));
      chk("sat_cnt", int'(cs), (i < 9) ? i : 9);
      chk("sat_tc", int'(ts), int'(i >= 10));
    end

    // Count down from reset
    do_reset();
    up_dn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("dn_cnt", int'(count),
          (i == 1) ? 9 : 10 - i);
      chk("dn_tc", int'(tc), int'(i == 1));
      chk("sat_dn_cnt", int'(cs), 0);
      chk("sat_dn_tc", int'(ts), 1);
    end

    // Held button: one toggle at k+2
    do_reset();
    up_dn = 1'b1;
    tick(); tick();
    run_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_run", int'(running),
          int'(i < 2));
    end
    run_btn = 1'b0;
    frozen = int'(count);
    chk("frozen", frozen, 5);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frz_cnt", int'(count), frozen);
      chk("frz_run", int'(running), 0);
    end
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
    tick(); tick();
    chk("resume_run", int'(running), 1);
    chk("resume_cnt", int'(count), frozen);
    tick();
    chk("resume_step", int'(count), frozen + 1);

    // Preload while paused, including clamping
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
    tick(); tick();
    chk("paused", int'(running), 0);
    load = 1'b1;
    load_val = 4'd4;
    tick();
    chk("pld4", int'(count), 4);
    load_val = 4'd13;
    tick();
    chk("pld13", int'(count), 9);
    chk("pld13_tc", int'(tc), 0);
    load = 1'b0;
    tick();
    chk("phold", int'(count), 9);

    // Reset mid-count
    do_reset();
    up_dn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst", int'(count), 6);
    do_reset();
    tick();
    chk("post_rst", int'(count), 1);

    // Randomised run against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      if ($urandom_range(0, 7) == 0)
        run_btn = ~run_btn;
      if ($urandom_range(0, 5) == 0)
        up_dn = ~up_dn;
      load = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
